// File: rtl/fetch_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_decode_stage
// Description : Fetch stage and IF/ID pipeline register of the 5-stage MIPS
//               core. Holds the PC, forms PC+4, selects the next PC
//               (jump > branch > sequential) and latches the fetched
//               instruction for Decode. Instruction memory is external and
//               read combinationally at PCF.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               StallF, StallD    - hold PC / hold IF/ID (from hazard_unit)
//               PCSrcD, JumpD     - branch taken / jump, resolved in Decode
//               PCBranchD         - branch target from Decode
//               PCF, InstrF       - fetch address out, instruction in
//               InstrD, PCPlus4D  - Decode-side instruction and its PC+4
//               ValidD            - InstrD is real (0 = bubble)
//               FlushD            - PCSrcD | JumpD, for monitoring
//               StallCntF, FlushCntD - optional stall/flush cycle counters
// Options     : FETCH_STALL_COUNT_EN - when defined, builds the saturating
//               stall/flush counters; otherwise both outputs are tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_decode_stage #(
    parameter int unsigned WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             StallF,
    input  logic             StallD,
    input  logic             PCSrcD,
    input  logic             JumpD,
    input  logic [WIDTH-1:0] PCBranchD,
    output logic [WIDTH-1:0] PCF,
    input  logic [31:0]      InstrF,
    output logic [31:0]      InstrD,
    output logic [WIDTH-1:0] PCPlus4D,
    output logic             ValidD,
    output logic             FlushD,
    output logic [31:0]      StallCntF,
    output logic [31:0]      FlushCntD
);

    localparam logic [WIDTH-1:0] c_PC_INC = WIDTH'(4);

    logic [WIDTH-1:0] r_pcF;
    logic [31:0]      r_instrD;
    logic [WIDTH-1:0] r_pcPlus4D;
    logic             r_validD;

    logic [WIDTH-1:0] w_pcPlus4F;
    logic [WIDTH-1:0] w_jumpTarget;
    logic [WIDTH-1:0] w_pcNext;
    logic             w_flushD;

    // Wraps modulo 2^WIDTH by construction of the adder width.
    assign w_pcPlus4F = r_pcF + c_PC_INC;

    // Pseudo-direct jump: upper PC bits of the Decode instruction's PC+4,
    // 26-bit index, word aligned. Assumes WIDTH >= 32.
    assign w_jumpTarget = {r_pcPlus4D[WIDTH-1:28], r_instrD[25:0], 2'b00};

    assign w_flushD = PCSrcD | JumpD;

    always_comb begin
        w_pcNext = w_pcPlus4F;
        if (JumpD) begin
            w_pcNext = w_jumpTarget;
        end else if (PCSrcD) begin
            w_pcNext = PCBranchD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcF <= RESET_PC;
        end else if (!StallF) begin
            r_pcF <= w_pcNext;
        end
    end

    // Stall beats flush: a held Decode instruction must not be turned into
    // a bubble while the hazard unit is still waiting on it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instrD   <= '0;
            r_pcPlus4D <= '0;
            r_validD   <= 1'b0;
        end else if (!StallD) begin
            if (w_flushD) begin
                r_instrD   <= '0;
                r_pcPlus4D <= '0;
                r_validD   <= 1'b0;
            end else begin
                r_instrD   <= InstrF;
                r_pcPlus4D <= w_pcPlus4F;
                r_validD   <= 1'b1;
            end
        end
    end

`ifdef FETCH_STALL_COUNT_EN
    logic [31:0] r_stallCntF;
    logic [31:0] r_flushCntD;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stallCntF <= '0;
            r_flushCntD <= '0;
        end else begin
            if (StallF && (r_stallCntF != 32'hFFFF_FFFF)) begin
                r_stallCntF <= r_stallCntF + 32'd1;
            end
            // Only flushes that actually insert a bubble are counted.
            if (!StallD && w_flushD && (r_flushCntD != 32'hFFFF_FFFF)) begin
                r_flushCntD <= r_flushCntD + 32'd1;
            end
        end
    end

    assign StallCntF = r_stallCntF;
    assign FlushCntD = r_flushCntD;
`else
    assign StallCntF = 32'd0;
    assign FlushCntD = 32'd0;
`endif

    assign PCF      = r_pcF;
    assign InstrD   = r_instrD;
    assign PCPlus4D = r_pcPlus4D;
    assign ValidD   = r_validD;
    assign FlushD   = w_flushD;

endmodule
`default_nettype wire
